// File: rtl/md_sched_pkg.sv
// Shared op codes, FSM encoding and decode helper for the E-stage multiply/divide scheduler.
package md_sched_pkg;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MFHI  = 4'd7;
   localparam logic [3:0] MD_MFLO  = 4'd8;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_sched_if.sv
// E-stage control/operand request bundle plus the scheduler's status and HI/LO read-back.
interface md_sched_if;
   logic        md_start;
   logic [3:0]  md_op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_out;

   modport master (
      output md_start, md_op, rs_data, rt_data,
      input  busy, md_stall, hi, lo, md_out
   );

   modport slave (
      input  md_start, md_op, rs_data, rt_data,
      output busy, md_stall, hi, lo, md_out
   );
endinterface

// File: rtl/md_sched_arith.sv
// Combinational {hi,lo} result for the latched mul/div op; divide by zero returns the current HI/LO.
module md_arith
   import md_sched_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [31:0] i_hi,
   input  logic [31:0] i_lo,
   output logic [63:0] o_res
);

   logic signed [63:0] w_prod_s;
   logic [63:0]        w_prod_u;
   logic [31:0]        w_div_b;
   logic [31:0]        w_mag_a;
   logic [31:0]        w_mag_b;
   logic [31:0]        w_sq;
   logic [31:0]        w_sr;
   logic [31:0]        w_uq;
   logic [31:0]        w_ur;
   logic               w_b_zero;

   assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   assign w_b_zero = (i_b == 32'd0);
   assign w_div_b  = w_b_zero ? 32'd1 : i_b;

   // Signed divide on magnitudes: -2^31 has magnitude 2^31 as unsigned, so MIN/-1 wraps to MIN.
   assign w_mag_a = i_a[31] ? (32'd0 - i_a) : i_a;
   assign w_mag_b = w_div_b[31] ? (32'd0 - w_div_b) : w_div_b;
   assign w_sq    = w_mag_a / w_mag_b;
   assign w_sr    = w_mag_a % w_mag_b;
   assign w_uq    = i_a / w_div_b;
   assign w_ur    = i_a % w_div_b;

   always_comb begin
      o_res = {i_hi, i_lo};
      case (i_op)
         MD_MULT:  o_res = w_prod_s;
         MD_MULTU: o_res = w_prod_u;
         MD_DIV: begin
            if (!w_b_zero) begin
               o_res[31:0]  = (i_a[31] ^ i_b[31]) ? (32'd0 - w_sq) : w_sq;
               o_res[63:32] = i_a[31] ? (32'd0 - w_sr) : w_sr;
            end
         end
         MD_DIVU: begin
            if (!w_b_zero) o_res = {w_ur, w_uq};
         end
         default: o_res = {i_hi, i_lo};
      endcase
   end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: fixed MULT_CYCLES/DIV_CYCLES busy window, owns HI/LO.
// md_stall is high on the start cycle (combinational) and on every busy cycle.
module md_sched
   import md_sched_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic      clk,
   input  logic      reset,
   md_sched_if.slave md_if
);

   localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W = ($clog2(MAX_N + 1) < 4) ? 4 : $clog2(MAX_N + 1);

   md_state_e        r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [3:0]       r_op, w_op_nxt;
   logic [31:0]      r_rs, w_rs_nxt;
   logic [31:0]      r_rt, w_rt_nxt;
   logic [31:0]      r_hi, w_hi_nxt;
   logic [31:0]      r_lo, w_lo_nxt;
   logic [63:0]      w_res;

   md_arith u_arith (
      .i_op  (r_op),
      .i_a   (r_rs),
      .i_b   (r_rt),
      .i_hi  (r_hi),
      .i_lo  (r_lo),
      .o_res (w_res)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
         r_op    <= MD_NONE;
         r_rs    <= '0;
         r_rt    <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_op    <= w_op_nxt;
         r_rs    <= w_rs_nxt;
         r_rt    <= w_rt_nxt;
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_op_nxt    = r_op;
      w_rs_nxt    = r_rs;
      w_rt_nxt    = r_rt;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;
      case (r_state)
         MD_IDLE: begin
            if (md_if.md_start) begin
               if (is_muldiv(md_if.md_op)) begin
                  w_state_nxt = MD_RUN;
                  w_op_nxt    = md_if.md_op;
                  w_rs_nxt    = md_if.rs_data;
                  w_rt_nxt    = md_if.rt_data;
                  w_cnt_nxt   = ((md_if.md_op == MD_MULT) || (md_if.md_op == MD_MULTU)) ?
                                CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               end else if (md_if.md_op == MD_MTHI) begin
                  w_hi_nxt = md_if.rs_data;
               end else if (md_if.md_op == MD_MTLO) begin
                  w_lo_nxt = md_if.rs_data;
               end
            end
         end
         MD_RUN: begin
            // Requests arriving while running are dropped; the stall unit prevents them.
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = MD_IDLE;
               w_hi_nxt    = w_res[63:32];
               w_lo_nxt    = w_res[31:0];
            end
         end
         default: w_state_nxt = MD_IDLE;
      endcase
   end

   assign md_if.busy     = (r_state == MD_RUN);
   assign md_if.md_stall = md_if.busy | (md_if.md_start & is_muldiv(md_if.md_op));
   assign md_if.hi       = r_hi;
   assign md_if.lo       = r_lo;
   assign md_if.md_out   = (md_if.md_op == MD_MFHI) ? r_hi :
                           (md_if.md_op == MD_MFLO) ? r_lo : 32'd0;

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the E stage of the five-stage pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests from the E-stage control decode. It runs a fixed-latency busy sequence and owns the HI/LO registers. It exports a stall request that the stall unit combines with "D-stage instruction is an MD-class instruction" to hold F/D and bubble E.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- md_start  in  1  E-stage instruction is MD-class this cycle
- md_op  in  4  operation code (constants below)
- rs_data  in  32  forwarded rs operand (E-stage forward mux output)
- rt_data  in  32  forwarded rt operand
- busy  out  1  multi-cycle operation in progress
- md_stall  out  1  busy | (md_start & md_op is MULT/MULTU/DIV/DIVU)
- hi  out  32  HI register
- lo  out  32  LO register
- md_out  out  32  hi when md_op==MFHI, lo when MFLO, else 0 (combinational)

## Operation
- States: IDLE, RUN. A down-counter `cnt` (4 bits minimum, sized to max(MULT_CYCLES, DIV_CYCLES)) holds the remaining cycles. A latched op and latched operands are held in RUN.
- IDLE with md_start and a multiply/divide op: latch rs_data, rt_data and md_op; cnt ← N (MULT_CYCLES or DIV_CYCLES); go to RUN.
- IDLE with md_start and MTHI: hi ← rs_data at the edge. MTLO: lo ← rs_data. No busy.
- IDLE with md_start and MFHI/MFLO or MD_NONE: no state change.
- RUN: cnt decrements each edge. At the edge where cnt==1, {hi,lo} is written with the result and the state returns to IDLE.
- Any md_start while RUN is ignored. The stall unit guarantees this never occurs; the bench asserts on it.
- MULT: signed 32×32→64, hi=[63:32], lo=[31:0]. MULTU: unsigned.
- DIV: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (rt latched == 0): full DIV_CYCLES busy, hi/lo unchanged.
- Results are computed from the latched operands, never from live inputs.

## Timing
- Reset: state=IDLE, cnt=0, busy=0, hi=0, lo=0, latched operands=0. md_stall is then 0 unless md_start with a mul/div op is asserted.
- Reset mid-RUN aborts the operation with no HI/LO write. reset has priority over every other event in the same cycle.
- Start sampled at cycle t: busy=1 in cycles t+1 … t+N. New hi/lo is visible from cycle t+N+1, when busy=0.
- md_stall is high in cycle t (combinational from md_start) and in t+1 … t+N. An MFHI/MFLO in D therefore cannot enter E before t+N+1.
- MTHI/MTLO: new value is visible the cycle after md_start.
- md_out is combinational in the same cycle and reflects hi/lo as of that cycle, with no internal bypass. Same-cycle MTHI followed by MFHI is impossible in-order.

## Structure
- Shared header constant.v gains:
  - `MD_NONE`=0, `MD_MULT`=1, `MD_MULTU`=2, `MD_DIV`=3, `MD_DIVU`=4, `MD_MTHI`=5, `MD_MTLO`=6, `MD_MFHI`=7, `MD_MFLO`=8.
  - `MD_IDLE`/`MD_RUN` state encodings.
- The CU gains an MDOp output and an md_start output. The SU consumes md_stall.
- One sub-module, md_arith: purely combinational. Takes the latched op and operands and produces the 64-bit {hi,lo} result, including the signed-division and divide-by-zero rules. md_sched keeps the FSM, counter and registers.

## Test plan
- Reset, then MULT rs=0xFFFFFFFE (−2), rt=3 → busy high for exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001. md_stall is high on the start cycle and on all 5 busy cycles.
- DIV −7/2 → 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 with hi=0x11, lo=0x22 beforehand → 10 busy cycles, hi/lo remain 0x11/0x22.
- MTHI rs=0xDEADBEEF, next cycle MFHI → md_out=0xDEADBEEF, busy never asserted. MTLO then MFLO behaves likewise.
- DIV started, reset asserted on the 4th busy cycle → next cycle busy=0, hi=lo=0, and a fresh MULT 2×3 then completes normally (lo=6).
- md_start with MULT asserted during RUN → ignored: the original result and timing are unaffected, and the bench assertion fires.
